// File: rtl/apuf_eval_ctrl_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation sequencer.
// Holds the FSM state encoding, the vote-counter width and parameter checks.
// Imported by the top; no logic of its own.
package apuf_eval_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FIRE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RELAX = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Width of the evaluation and ones counters (up to 31 evaluations).
  localparam int ONES_W = 5;

  // Majority voting needs an odd count that fits the 5-bit counters.
  function automatic bit num_eval_legal(input int n);
    return (n >= 1) && (n <= 31) && ((n % 2) == 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apuf_eval_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk.
// Latency: 2 clk cycles.
// No handshake; the level is sampled every cycle.
module apuf_eval_ctrl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops resolve metastability before the FSM sees the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF sequencer: latch challenge, settle, trigger NUM_EVAL times, majority-vote.
// Latency: 1 + SETTLE_CYC + NUM_EVAL*(4 + GAP_CYC) + 1 cycles with a 1-cycle PUF (+-1 per eval).
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module apuf_eval_ctrl
  import apuf_eval_ctrl_pkg::*;
#(
  parameter int CW          = 64,
  parameter int NUM_EVAL    = 5,
  parameter int SETTLE_CYC  = 4,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CW-1:0]     chal_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              resp_o,
  output logic [ONES_W-1:0] ones_cnt_o,
  output logic              timeout_err_o,
  output logic              puf_vcc_o,
  output logic              puf_tig_o,
  output logic [CW-1:0]     puf_c_o,
  input  logic              puf_resp_ready_i,
  input  logic              puf_resp_bit_i
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W  = $clog2(max2(SETTLE_CYC, GAP_CYC) + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [ONES_W-1:0] EVAL_TOTAL  = ONES_W'(NUM_EVAL);
  localparam logic [ONES_W-1:0] EVAL_HALF   = ONES_W'(NUM_EVAL / 2);

  if (!num_eval_legal(NUM_EVAL)) begin : g_bad_num_eval
    $error("apuf_eval_ctrl: NUM_EVAL must be odd and within 1..31");
  end

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [ONES_W-1:0]   eval_q;
  logic [ONES_W-1:0]   ones_q;
  logic                err_q;
  logic                rdy_prev_q;
  logic                busy_q;
  logic                done_q;
  logic                resp_q;
  logic [ONES_W-1:0]   ones_cnt_q;
  logic                terr_q;
  logic                vcc_q;
  logic                tig_q;
  logic [CW-1:0]       puf_c_q;

  logic                rdy_s;
  logic                bit_s;
  logic                rdy_rise_d;
  logic                relax_to_d;
  logic                relax_go_d;
  logic [ONES_W-1:0]   ones_d;
  logic [ONES_W-1:0]   eval_d;

  // The PUF answers asynchronously; both ready and bit take the same two-flop path
  // so the bit is already stable when the ready edge is seen.
  apuf_eval_ctrl_sync2 u_sync_rdy (
    .clk (clk),
    .rst (rst),
    .d_i (puf_resp_ready_i),
    .q_o (rdy_s)
  );

  apuf_eval_ctrl_sync2 u_sync_bit (
    .clk (clk),
    .rst (rst),
    .d_i (puf_resp_bit_i),
    .q_o (bit_s)
  );

  // Decode edge, relax exit conditions and the next vote counts.
  always_comb begin
    rdy_rise_d = rdy_s && !rdy_prev_q;
    relax_to_d = rdy_s && (wait_q == WAIT_LAST);
    relax_go_d = ((cnt_q == GAP_LAST) && !rdy_s) || relax_to_d;
    ones_d     = ones_q + {{(ONES_W-1){1'b0}}, bit_s};
    eval_d     = eval_q + {{(ONES_W-1){1'b0}}, 1'b1};
  end

  // Sequencer FSM; every output, counter and PUF-side signal is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      eval_q     <= '0;
      ones_q     <= '0;
      err_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= 1'b0;
      ones_cnt_q <= '0;
      terr_q     <= 1'b0;
      vcc_q      <= 1'b0;
      tig_q      <= 1'b0;
      puf_c_q    <= '0;
    end else begin
      rdy_prev_q <= rdy_s;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            puf_c_q <= chal_i;
            ones_q  <= '0;
            eval_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            vcc_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_FIRE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIRE: begin
          tig_q   <= 1'b1;
          wait_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rdy_rise_d || (wait_q == WAIT_LAST)) begin
            if (rdy_rise_d) ones_q <= ones_d;
            else            err_q  <= 1'b1;
            eval_q  <= eval_d;
            tig_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
            state_q <= ST_RELAX;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_RELAX: begin
          // Gap counter saturates; wait counter measures how long ready stays stuck high.
          if (cnt_q != GAP_LAST) cnt_q <= cnt_q + 1'b1;
          wait_q <= rdy_s ? wait_q + 1'b1 : '0;
          if (relax_go_d) begin
            cnt_q  <= '0;
            wait_q <= '0;
            if (relax_to_d) err_q <= 1'b1;
            if (eval_q < EVAL_TOTAL) begin
              state_q <= ST_FIRE;
            end else begin
              // Result and done are launched here so they are visible during DONE with busy.
              resp_q     <= (ones_q > EVAL_HALF);
              ones_cnt_q <= ones_q;
              terr_q     <= err_q | relax_to_d;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          vcc_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign resp_o        = resp_q;
  assign ones_cnt_o    = ones_cnt_q;
  assign timeout_err_o = terr_q;
  assign puf_vcc_o     = vcc_q;
  assign puf_tig_o     = tig_q;
  assign puf_c_o       = puf_c_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Bench for apuf_eval_ctrl with a behavioural arbiter-PUF model.
// Table of response patterns plus hand-written reset/disturb sequences.
// Expected results queued at start and checked when done appears.
module tb_apuf_eval_ctrl;
  import apuf_eval_ctrl_pkg::*;

  localparam int CW  = 64;
  localparam int NE  = 5;
  localparam int DLY = 2;
  localparam int TO  = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [CW-1:0]     chal_i;
  logic              busy_o;
  logic              done_o;
  logic              resp_o;
  logic [ONES_W-1:0] ones_cnt_o;
  logic              timeout_err_o;
  logic              puf_vcc_o;
  logic              puf_tig_o;
  logic [CW-1:0]     puf_c_o;
  logic              puf_resp_ready_i;
  logic              puf_resp_bit_i;

  always #5 clk = ~clk;

  apuf_eval_ctrl #(
    .CW(CW), .NUM_EVAL(NE), .SETTLE_CYC(4), .GAP_CYC(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .chal_i           (chal_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .resp_o           (resp_o),
    .ones_cnt_o       (ones_cnt_o),
    .timeout_err_o    (timeout_err_o),
    .puf_vcc_o        (puf_vcc_o),
    .puf_tig_o        (puf_tig_o),
    .puf_c_o          (puf_c_o),
    .puf_resp_ready_i (puf_resp_ready_i),
    .puf_resp_bit_i   (puf_resp_bit_i)
  );

  // PUF model: ready rises DLY cycles after trigger (unless that evaluation is muted),
  // drops when the trigger drops; counts trigger pulses and the longest trigger-high run.
  logic [4:0] bits_cfg;
  int         never_cfg;
  logic       mclr;
  int         ev, dcnt, hi_len, hi_max, tig_pulses;
  logic       tig_prev;

  always @(negedge clk) begin
    if (rst || mclr) begin
      puf_resp_ready_i = 1'b0;
      puf_resp_bit_i   = 1'b0;
      ev = 0; dcnt = 0; hi_len = 0; hi_max = 0; tig_pulses = 0;
      tig_prev = 1'b0;
    end else begin
      if (puf_tig_o && !tig_prev) begin
        tig_pulses++;
        dcnt   = 0;
        hi_len = 0;
      end
      if (puf_tig_o) begin
        hi_len++;
        if (hi_len > hi_max) hi_max = hi_len;
        dcnt++;
        if (dcnt >= DLY && ev != never_cfg && ev < NE) begin
          puf_resp_ready_i = 1'b1;
          puf_resp_bit_i   = bits_cfg[ev];
        end
      end else begin
        puf_resp_ready_i = 1'b0;
      end
      if (!puf_tig_o && tig_prev) ev++;
      tig_prev = puf_tig_o;
    end
  end

  typedef struct packed {
    logic              resp;
    logic [ONES_W-1:0] ones;
    logic              err;
  } exp_t;

  typedef struct {
    logic [4:0]        bits;
    int                never;
    logic              resp;
    logic [ONES_W-1:0] ones;
    logic              err;
    bit                disturb;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_tig(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (puf_tig_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic configure(input vec_t v);
    bits_cfg  = v.bits;
    never_cfg = v.never;
    @(posedge clk); mclr = 1'b1;
    @(posedge clk); mclr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [CW-1:0] ch, input string tag);
    bit   ok;
    bit   seen;
    int   extra;
    exp_t e;
    configure(v);
    exp_q.push_back('{resp: v.resp, ones: v.ones, err: v.err});
    @(negedge clk); start_i = 1'b1; chal_i = ch;
    @(negedge clk); start_i = 1'b0; chal_i = ~ch;
    chk({tag, "_busy_start"}, busy_o, 1);
    chk({tag, "_vcc_start"}, puf_vcc_o, 1);
    chk({tag, "_puf_c"}, puf_c_o, ch);
    if (v.disturb) begin
      wait_tig(ok);
      chk({tag, "_tig_seen"}, ok, 1);
      start_i = 1'b1; chal_i = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      start_i = 1'b0;
      chk({tag, "_puf_c_hold"}, puf_c_o, ch);
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      e = exp_q.pop_front();
      chk({tag, "_resp"}, resp_o, e.resp);
      chk({tag, "_ones"}, ones_cnt_o, e.ones);
      chk({tag, "_err"}, timeout_err_o, e.err);
      chk({tag, "_busy_done"}, busy_o, 1);
    end else begin
      exp_q.delete();
    end
    @(negedge clk);
    chk({tag, "_vcc_after"}, puf_vcc_o, 0);
    chk({tag, "_busy_after"}, busy_o, 0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    chk({tag, "_single_done"}, extra, 0);
    chk({tag, "_tig_pulses"}, tig_pulses, NE);
    chk({tag, "_tig_hi_max"}, hi_max, (v.never >= 0) ? TO : DLY + 2);
  endtask

  vec_t tbl[6];

  initial begin
    bit   ok;
    int   dn;
    logic [CW-1:0] ch;

    tbl[0] = '{bits: 5'b01011, never: -1, resp: 1'b1, ones: 5'd3, err: 1'b0, disturb: 1'b0};
    tbl[1] = '{bits: 5'b10100, never: -1, resp: 1'b0, ones: 5'd2, err: 1'b0, disturb: 1'b0};
    tbl[2] = '{bits: 5'b11111, never:  1, resp: 1'b1, ones: 5'd4, err: 1'b1, disturb: 1'b0};
    tbl[3] = '{bits: 5'b10101, never: -1, resp: 1'b1, ones: 5'd3, err: 1'b0, disturb: 1'b1};
    tbl[4] = '{bits: 5'b00000, never: -1, resp: 1'b0, ones: 5'd0, err: 1'b0, disturb: 1'b0};
    tbl[5] = '{bits: 5'b11111, never: -1, resp: 1'b1, ones: 5'd5, err: 1'b0, disturb: 1'b0};

    rst = 1'b1; start_i = 1'b0; chal_i = '0; mclr = 1'b0;
    bits_cfg = '0; never_cfg = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_resp", resp_o, 0);
    chk("rst_ones", ones_cnt_o, 0);
    chk("rst_err", timeout_err_o, 0);
    chk("rst_vcc", puf_vcc_o, 0);
    chk("rst_tig", puf_tig_o, 0);
    chk("rst_puf_c", puf_c_o, 0);

    for (int i = 0; i < 6; i++) begin
      ch = (i == 0) ? 64'hA5A5_0000_FFFF_1234 : {$urandom, $urandom};
      run_vec(tbl[i], ch, $sformatf("v%0d", i));
    end

    // Reset in the middle of an evaluation: PUF side drops at once, no done follows.
    configure(tbl[0]);
    exp_q.push_back('{resp: 1'b1, ones: 5'd3, err: 1'b0});
    @(negedge clk); start_i = 1'b1; chal_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); start_i = 1'b0;
    wait_tig(ok);
    chk("mid_rst_tig_seen", ok, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tig", puf_tig_o, 0);
    chk("mid_rst_vcc", puf_vcc_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_puf_c", puf_c_o, 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    exp_q.delete();
    run_vec(tbl[1], 64'hDEAD_BEEF_0BAD_F00D, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
